// File: rtl/hack_data_memory.sv
// Hack CPU data-memory responder: 16K RAM, 8K screen RAM with a registered
// scanner read port, and a keyboard register backed by a small key FIFO.
module hack_data_memory #(
    parameter int KBD_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [14:0]                    address,
    input  logic [15:0]                    outM,
    input  logic                           writeM,
    output logic [15:0]                    inM,
    input  logic [15:0]                    kbd_code,
    input  logic                           kbd_valid,
    output logic                           kbd_ready,
    output logic [$clog2(KBD_DEPTH+1)-1:0] kbd_level,
    input  logic [12:0]                    scr_addr,
    output logic [15:0]                    scr_data
);

    localparam int PW = $clog2(KBD_DEPTH);
    localparam int LW = $clog2(KBD_DEPTH + 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(KBD_DEPTH);

    // Handshake: a key is pushed at a rising edge when kbd_valid && kbd_ready;
    // kbd_ready depends only on occupancy, and the source holds kbd_code until taken.

    logic [15:0] ram_mem  [0:16383];
    logic [15:0] scr_mem  [0:8191];
    logic [15:0] fifo_mem [0:KBD_DEPTH-1];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   scr_data_q, scr_data_d;

    logic        sel_ram, sel_scr, sel_kbd;
    logic        push, pop;
    logic [15:0] kbd_rdata;

    always_comb begin
        sel_ram = ~address[14];
        sel_scr = (address[14:13] == 2'b10);
        sel_kbd = (address == 15'h6000);
    end

    always_comb begin
        kbd_ready = (level_q != LEVEL_FULL);
        push      = kbd_valid && kbd_ready;
        // A KBD write is a pop; an empty FIFO makes it a no-op.
        pop       = writeM && sel_kbd && (level_q != '0);
        kbd_rdata = (level_q != '0) ? fifo_mem[rd_ptr_q] : 16'h0000;
    end

    always_comb begin
        inM = 16'h0000;
        if (sel_ram) begin
            inM = ram_mem[address[13:0]];
        end else if (sel_scr) begin
            inM = scr_mem[address[12:0]];
        end else if (sel_kbd) begin
            inM = kbd_rdata;
        end
    end

    always_comb begin
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        scr_data_d = scr_mem[scr_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            scr_data_q <= 16'h0000;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            scr_data_q <= scr_data_d;
        end
    end

    // Storage arrays carry no reset; the FIFO level masks stale entries.
    always_ff @(posedge clk) begin
        if (writeM && sel_ram) begin
            ram_mem[address[13:0]] <= outM;
        end
        if (writeM && sel_scr) begin
            scr_mem[address[12:0]] <= outM;
        end
        if (push) begin
            fifo_mem[wr_ptr_q] <= kbd_code;
        end
    end

    assign kbd_level = level_q;
    assign scr_data  = scr_data_q;

endmodule

// File: tb/tb_hack_data_memory.sv
// Self-checking bench for hack_data_memory: RAM, screen scan port, key FIFO,
// unmapped space and asynchronous reset, checked against a key/data scoreboard.
module tb_hack_data_memory;

    localparam int KBD_DEPTH = 4;
    localparam int LW = $clog2(KBD_DEPTH + 1);

    logic          clk;
    logic          reset_n;
    logic [14:0]   address;
    logic [15:0]   outM;
    logic          writeM;
    logic [15:0]   inM;
    logic [15:0]   kbd_code;
    logic          kbd_valid;
    logic          kbd_ready;
    logic [LW-1:0] kbd_level;
    logic [12:0]   scr_addr;
    logic [15:0]   scr_data;

    int checks = 0;
    int errors = 0;

    // exp_q holds queued key codes (the FIFO model); data_q holds memory read expectations.
    logic [15:0] exp_q[$];
    logic [15:0] data_q[$];

    hack_data_memory #(.KBD_DEPTH(KBD_DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .outM      (outM),
        .writeM    (writeM),
        .inM       (inM),
        .kbd_code  (kbd_code),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready),
        .kbd_level (kbd_level),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic cpu_wr(input logic [14:0] a, input logic [15:0] d);
        address = a;
        outM    = d;
        writeM  = 1'b1;
        tick();
        writeM  = 1'b0;
    endtask

    task automatic cpu_rd(input string tag, input logic [14:0] a);
        address = a;
        writeM  = 1'b0;
        #1;
        check_eq(tag, inM, data_q.pop_front());
        tick();
    endtask

    task automatic kbd_push(input logic [15:0] code);
        kbd_code  = code;
        kbd_valid = 1'b1;
        for (int n = 0; n < 20 && !kbd_ready; n++) tick();
        if (!kbd_ready) begin
            check_eq("kbd_ready_timeout", {15'h0, kbd_ready}, 16'h0001);
        end else begin
            tick();
            exp_q.push_back(code);
        end
        kbd_valid = 1'b0;
    endtask

    task automatic kbd_pop();
        cpu_wr(15'h6000, 16'($urandom_range(0, 16'hFFFF)));
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    // scoreboard compare of the keyboard register against the model
    task automatic kbd_check(input string tag);
        logic [15:0] exp_head;
        exp_head = (exp_q.size() != 0) ? exp_q[0] : 16'h0000;
        address = 15'h6000;
        writeM  = 1'b0;
        #1;
        check_eq({tag, "_head"}, inM, exp_head);
        check_eq({tag, "_level"}, 16'(kbd_level), 16'(exp_q.size()));
        check_eq({tag, "_ready"}, {15'h0, kbd_ready}, {15'h0, exp_q.size() != KBD_DEPTH});
    endtask

    logic [15:0] codes [0:5];

    initial begin
        reset_n   = 1'b0;
        address   = '0;
        outM      = '0;
        writeM    = 1'b0;
        kbd_code  = '0;
        kbd_valid = 1'b0;
        scr_addr  = '0;
        for (int i = 0; i < 6; i++) codes[i] = 16'h0041 + 16'(i);

        #3;
        check_eq("rst_level", 16'(kbd_level), 16'h0000);
        check_eq("rst_ready", {15'h0, kbd_ready}, 16'h0001);
        check_eq("rst_scr_data", scr_data, 16'h0000);
        #9 reset_n = 1'b1;
        tick();
        kbd_check("rst_kbd");
        tick();

        // RAM write/read, including old value visible during the write cycle
        cpu_wr(15'h0005, 16'h1111);
        address = 15'h0005; outM = 16'h1234; writeM = 1'b1;
        #1;
        check_eq("ram_old_during_write", inM, 16'h1111);
        tick();
        writeM = 1'b0;
        data_q.push_back(16'h1234);
        cpu_rd("ram_new_after_edge", 15'h0005);
        cpu_wr(15'h3FFF, 16'hBEEF); data_q.push_back(16'hBEEF);
        cpu_rd("ram_top", 15'h3FFF);
        data_q.push_back(16'h1234);
        cpu_rd("ram_low_again", 15'h0005);

        // screen dual port
        cpu_wr(15'h4010, 16'h0F0F);
        address = 15'h4010; outM = 16'hA5A5; writeM = 1'b1; scr_addr = 13'h010;
        tick();
        writeM = 1'b0;
        check_eq("scr_same_cycle_old", scr_data, 16'h0F0F);
        tick();
        check_eq("scr_scan_new", scr_data, 16'hA5A5);
        data_q.push_back(16'hA5A5);
        cpu_rd("scr_cpu_read", 15'h4010);
        cpu_wr(15'h5FFF, 16'h5A5A); data_q.push_back(16'h5A5A);
        cpu_rd("scr_top", 15'h5FFF);

        // keyboard FIFO basic
        kbd_push(codes[0]);
        kbd_push(codes[1]);
        kbd_check("kbd_two");
        kbd_pop();
        kbd_check("kbd_pop1");
        kbd_pop();
        kbd_check("kbd_pop2");

        // full and backpressure
        for (int i = 0; i < 4; i++) kbd_push(codes[i]);
        kbd_check("kbd_full");
        kbd_code = codes[4]; kbd_valid = 1'b1;
        tick();
        kbd_check("kbd_full_ignored");
        address = 15'h6000; writeM = 1'b1;
        tick();
        writeM = 1'b0;
        void'(exp_q.pop_front());
        kbd_check("kbd_full_pop_only");
        tick();
        kbd_valid = 1'b0;
        exp_q.push_back(codes[4]);
        kbd_check("kbd_fifth_accepted");
        kbd_pop();
        kbd_pop();
        kbd_check("kbd_level2");
        kbd_code = codes[5]; kbd_valid = 1'b1; address = 15'h6000; writeM = 1'b1;
        tick();
        kbd_valid = 1'b0; writeM = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(codes[5]);
        kbd_check("kbd_push_pop_mid");
        while (exp_q.size() != 0) begin
            kbd_check("kbd_drain");
            kbd_pop();
        end

        // empty edge cases
        kbd_pop();
        kbd_check("kbd_pop_empty");
        kbd_code = 16'h00AA; kbd_valid = 1'b1; address = 15'h6000; writeM = 1'b1;
        tick();
        kbd_valid = 1'b0; writeM = 1'b0;
        exp_q.push_back(16'h00AA);
        kbd_check("kbd_push_pop_empty");

        // unmapped space
        cpu_wr(15'h6005, 16'hFFFF); data_q.push_back(16'h0000);
        cpu_rd("unmapped_6005", 15'h6005);
        cpu_wr(15'h7FFF, 16'h1357); data_q.push_back(16'h0000);
        cpu_rd("unmapped_7fff", 15'h7FFF);

        // asynchronous reset mid-cycle with keys queued
        kbd_push(16'h0101);
        kbd_push(16'h0202);
        kbd_check("kbd_level3");
        check_eq("scr_before_reset", scr_data, 16'hA5A5);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check_eq("async_rst_level", 16'(kbd_level), 16'h0000);
        check_eq("async_rst_ready", {15'h0, kbd_ready}, 16'h0001);
        check_eq("async_rst_scr", scr_data, 16'h0000);
        #2 reset_n = 1'b1;
        tick();
        kbd_check("post_reset_kbd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Responder end of the Hack CPU data-memory interface: accepts the CPU's address/outM/writeM and returns inM.
- Maps 16K-word RAM at 0x0000-0x3FFF, 8K-word screen RAM at 0x4000-0x5FFF, and a keyboard register at 0x6000.
- The keyboard register is backed by a small key FIFO fed by a valid/ready keyboard source.
- A second, registered read port lets a display scanner fetch screen words independently of the CPU.

Parameters:
- KBD_DEPTH, 4, key FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  15  CPU data address.
- outM  input  16  CPU write data.
- writeM  input  1  CPU write strobe, sampled at rising edge.
- inM  output  16  read data to CPU; combinational from address.
- kbd_code  input  16  key code offered by keyboard source.
- kbd_valid  input  1  kbd_code is valid this cycle.
- kbd_ready  output  1  FIFO can accept; high when not full.
- kbd_level  output  $clog2(KBD_DEPTH+1)  current FIFO occupancy.
- scr_addr  input  13  display scanner word index into screen RAM.
- scr_data  output  16  screen word, registered, 1-cycle latency.

Behaviour:
Address decode, using address[14:13]:
- 00/01: RAM word address[13:0].
- 10: screen word address[12:0].
- 11 with address == 0x6000: KBD.
- Any other address (0x6001-0x7FFF): reads 0, writes ignored.

CPU reads:
- inM is combinational, zero latency, and reflects state before the next edge.
- A read of a location written in the same cycle returns the old value; the new value is visible after the edge.

CPU writes (writeM=1 at rising edge):
- RAM or screen: the location takes outM.
- KBD: the write pops the FIFO head; the data value is ignored. A pop when empty is a no-op.

KBD read value:
- FIFO head when kbd_level > 0, else 16'h0000.
- Reading never pops.

Key FIFO:
- Push occurs when kbd_valid && kbd_ready at the edge.
- kbd_ready = (kbd_level != KBD_DEPTH), combinational, with no dependency on kbd_valid.
- Full: kbd_ready=0, kbd_valid is ignored, and the source must hold kbd_code until ready.
- Push and pop in the same cycle:
  - Non-empty and not full: both take effect, level unchanged, head advances.
  - Full: kbd_ready is already 0, so only the pop occurs and level decreases by 1.
  - Empty: the push succeeds, the pop is a no-op, level becomes 1, and the new entry becomes head after the edge.
- Read/write pointers wrap modulo KBD_DEPTH.
- Level saturates by construction: it never exceeds KBD_DEPTH and never goes below 0.

Screen scan port:
- scr_data <= screen[scr_addr] each edge.
- If the CPU writes the same screen word in that cycle, scr_data gets the old value.

Reset (reset_n=0, asynchronous):
- FIFO emptied: pointers 0, kbd_level=0, kbd_ready=1, KBD reads 0.
- scr_data=0.
- RAM and screen contents are not cleared and are undefined until written.
- Reset asserted mid-stream discards any queued keys. A push or pop coincident with reset release is not taken in that cycle.

No other state. Handle the unsigned 16-bit data path without sign manipulation.

Test Plan:
1. RAM write/read: write 0x1234 to 0x0005, then 0xBEEF to 0x3FFF; read both → 0x1234, 0xBEEF. In the write cycle, inM shows the old value.
2. Screen dual port: CPU writes 0xA5A5 to 0x4010; next cycle scr_addr=0x010 → scr_data=0xA5A5 one edge later. A same-cycle write and scan of 0x010 returns the prior value.
3. Keyboard FIFO basic: push 0x0041, then 0x0042; KBD reads 0x0041 with level=2. Write to 0x6000 → KBD reads 0x0042. Write again → 0x0000, level=0.
4. Full/backpressure (KBD_DEPTH=4): push 5 codes with kbd_valid held → kbd_ready drops after the 4th and level=4; the 5th is accepted only after a pop. Push and pop in the same cycle at level 2 → level stays 2.
5. Empty edge cases: pop when empty → level 0, no underflow. Push and pop simultaneously when empty → level 1, KBD=pushed code.
6. Reset and unmapped: write to 0x6005 then read → 0. With level=3, pulse reset_n low mid-cycle → immediately level=0, kbd_ready=1, scr_data=0; RAM contents written earlier are unspecified.
